// File: rtl/reflet_debug_loader.sv
// UART byte receiver that assembles little-endian words for the debug loader.
// Flags a partial word via 'receiving' so the controller can hold the CPU.
module reflet_debug_loader #(
  parameter int wordsize     = 16,
  parameter int clk_freq     = 1000000,
  parameter int baud_rate    = 9600,
  parameter int timeout_bits = 40
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                rx,
  output logic [wordsize-1:0] word_out,
  output logic                word_valid,
  input  logic                word_ack,
  output logic                receiving,
  output logic                frame_error,
  output logic                overrun
);
  localparam int D  = clk_freq / baud_rate;
  localparam int H  = D / 2;
  localparam int HS = (H > 0) ? H - 1 : 0;
  localparam int N  = wordsize / 8;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam int TO = timeout_bits * D;
  localparam int TW = $clog2(TO + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]          sync;
  logic                rx_s;
  logic [1:0]          state;
  logic                armed;
  logic [CW-1:0]       cnt;
  logic [2:0]          bit_idx;
  logic [7:0]          rx_byte;
  logic [KW-1:0]       k;
  logic [TW-1:0]       tcnt;
  logic [wordsize-1:0] assembly, assembly_nxt;

  assign rx_s = sync[1];

  // Assembly register with the just-received byte dropped into slot k.
  always_comb begin
    assembly_nxt = assembly;
    for (int i = 0; i < N; i++)
      if (k == KW'(i)) assembly_nxt[8*i +: 8] = rx_byte;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync        <= 2'b11;
      state       <= S_IDLE;
      armed       <= 1'b0;
      cnt         <= '0;
      bit_idx     <= '0;
      rx_byte     <= '0;
      k           <= '0;
      tcnt        <= '0;
      assembly    <= '0;
      word_out    <= '0;
      word_valid  <= 1'b0;
      receiving   <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      sync        <= {sync[0], rx};
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      if (enable) begin
        if (word_valid && word_ack) word_valid <= 1'b0;

        // Partial word abandoned if the line stays quiet too long between bytes.
        if (state == S_IDLE && k != '0) begin
          if (tcnt == TW'(TO - 1)) begin
            k         <= '0;
            receiving <= 1'b0;
            tcnt      <= '0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end else begin
          tcnt <= '0;
        end

        case (state)
          S_IDLE: begin
            // Arming on a high line keeps a low stop bit from retriggering.
            if (!armed) armed <= rx_s;
            else if (!rx_s) begin
              state <= S_START;
              cnt   <= '0;
              armed <= 1'b0;
            end
          end
          S_START: begin
            if (cnt == CW'(HS)) begin
              cnt <= '0;
              if (rx_s) state <= S_IDLE;
              else begin
                state     <= S_DATA;
                bit_idx   <= '0;
                receiving <= 1'b1;
              end
            end else cnt <= cnt + CW'(1);
          end
          S_DATA: begin
            if (cnt == CW'(D - 1)) begin
              cnt     <= '0;
              rx_byte <= {rx_s, rx_byte[7:1]};
              if (bit_idx == 3'd7) state <= S_STOP;
              else bit_idx <= bit_idx + 3'd1;
            end else cnt <= cnt + CW'(1);
          end
          default: begin
            if (cnt == CW'(D - 1)) begin
              cnt   <= '0;
              state <= S_IDLE;
              if (rx_s) begin
                assembly <= assembly_nxt;
                if (k == KW'(N - 1)) begin
                  word_out   <= assembly_nxt;
                  word_valid <= 1'b1;
                  overrun    <= word_valid && !word_ack;
                  k          <= '0;
                  receiving  <= 1'b0;
                end else begin
                  k <= k + KW'(1);
                end
              end else begin
                frame_error <= 1'b1;
              end
            end else cnt <= cnt + CW'(1);
          end
        endcase
      end
    end
  end
endmodule
